// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU datapath, the aux (loader/debug) port,
// the arbiter and the single-port DataMemory.
// slave  : arbiter side (takes requests and memory read data, drives grants and memory controls)
// master : system side (CPU, aux port and DataMemory)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_gnt;
    logic [DATA_W-1:0] aux_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, aux_gnt, aux_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output aux_req, aux_we, aux_addr, aux_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, aux_gnt, aux_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMemory between the CPU datapath
// and the aux port. The CPU owns memory by default. The aux port gets the
// memory when the CPU is idle, or after MAX_WAIT blocked cycles. It then
// holds it for up to BURST_LEN grants while the CPU is waiting.
// Optional feature macro: DMEM_ARB_STATS_EN (adds the stall_cnt counter).
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_LEN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         bus,
    output logic [15:0]           stall_cnt
);
    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(BURST_LEN + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_TOP = BURST_W'(BURST_LEN - 1);

    typedef enum logic {OWN_CPU = 1'b0, OWN_AUX = 1'b1} owner_t;

    owner_t             r_owner, w_owner_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt, w_wait_nxt;
    logic [BURST_W-1:0] r_burst_cnt, w_burst_nxt;

    logic              w_sel_aux;
    logic              w_req;
    logic              w_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_cpu_stall;

    // Owner and fairness counters; async reset drops any aux tenure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_CPU;
            r_wait_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Ownership decision and counter updates for the next edge.
    always_comb begin
        w_owner_nxt = r_owner;
        w_wait_nxt  = r_wait_cnt;
        w_burst_nxt = r_burst_cnt;
        w_sel_aux   = 1'b0;
        case (r_owner)
            OWN_CPU: begin
                // CPU wins ties; aux takes over on an idle CPU or once starved.
                if (bus.aux_req && (!bus.cpu_req || r_wait_cnt == WAIT_MAX)) begin
                    w_owner_nxt = OWN_AUX;
                    w_wait_nxt  = '0;
                    w_burst_nxt = '0;
                end else if (!bus.aux_req) begin
                    w_wait_nxt = '0;
                end else if (r_wait_cnt != WAIT_MAX) begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            OWN_AUX: begin
                w_sel_aux  = 1'b1;
                w_wait_nxt = '0;
                if (!bus.aux_req) begin
                    w_owner_nxt = OWN_CPU;
                end else begin
                    // A waiting CPU reclaims memory after the last burst grant.
                    if (bus.cpu_req && r_burst_cnt == BURST_TOP)
                        w_owner_nxt = OWN_CPU;
                    if (r_burst_cnt != BURST_TOP)
                        w_burst_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: w_owner_nxt = OWN_CPU;
        endcase
    end

    // Memory port mux: exactly one requester drives the memory at a time.
    assign w_req       = w_sel_aux ? bus.aux_req   : bus.cpu_req;
    assign w_we        = w_sel_aux ? bus.aux_we    : bus.cpu_we;
    assign w_mem_addr  = w_sel_aux ? bus.aux_addr  : bus.cpu_addr;
    assign w_mem_wdata = w_sel_aux ? bus.aux_wdata : bus.cpu_wdata;
    assign w_cpu_stall = !rst && w_sel_aux && bus.cpu_req;

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    // Reset forces the memory quiet even though the CPU path is selected.
    assign bus.mem_read  = !rst && w_req && !w_we;
    assign bus.mem_write = !rst && w_req && w_we;
    assign bus.aux_gnt   = !rst && w_sel_aux && bus.aux_req;
    assign bus.cpu_stall = w_cpu_stall;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.aux_rdata = bus.mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of CPU stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_cpu_stall && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;
    localparam int AW = 8, DW = 8, MAX_WAIT = 4, BURST_LEN = 2;
`ifdef DMEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .stall_cnt(stall_cnt)
    );

    // DataMemory: comb read, write on the edge, cleared while rst is high.
    logic [DW-1:0] mem [0:255];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:255];
    bit  aux_holds;       // aux currently owns the memory
    int  aux_blocked;     // cycles aux has lost to the CPU
    int  aux_run;         // aux grants in the current tenure (saturating)
    int  stalls;          // CPU stall cycles so far
    int  n_tests = 0, n_fail = 0;

    // Per-cycle results left behind for the directed checks.
    logic       e_gnt, e_stall;
    logic       ob_gnt, ob_stall, ob_wr;
    logic [7:0] ob_addr, ob_ardata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        aux_holds   = 1'b0;
        aux_blocked = 0;
        aux_run     = 0;
        stalls      = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    task automatic drive_idle();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = '0; bus.aux_wdata = '0;
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step(input logic cr, input logic cwe, input logic [7:0] ca, input logic [7:0] cwd,
                        input logic ar, input logic awe, input logic [7:0] aa, input logic [7:0] awd);
        int srv;  // 0 nobody, 1 CPU, 2 aux
        @(posedge clk); #1;
        bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cwd;
        bus.aux_req = ar; bus.aux_we = awe; bus.aux_addr = aa; bus.aux_wdata = awd;
        @(negedge clk);
        srv     = aux_holds ? (ar ? 2 : 0) : (cr ? 1 : 0);
        e_gnt   = (srv == 2);
        e_stall = aux_holds && cr;
        chk("aux_gnt",   32'(bus.aux_gnt),   32'(e_gnt));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        chk("mem_write", 32'(bus.mem_write), 32'((srv == 1 && cwe) || (srv == 2 && awe)));
        chk("mem_read",  32'(bus.mem_read),  32'((srv == 1 && !cwe) || (srv == 2 && !awe)));
        if (srv != 0) chk("mem_addr", 32'(bus.mem_addr), 32'(srv == 1 ? ca : aa));
        if (srv == 1 && cwe)  chk("mem_wdata_cpu", 32'(bus.mem_wdata), 32'(cwd));
        if (srv == 2 && awe)  chk("mem_wdata_aux", 32'(bus.mem_wdata), 32'(awd));
        if (srv == 1 && !cwe) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(ref_mem[ca]));
        if (srv == 2 && !awe) chk("aux_rdata", 32'(bus.aux_rdata), 32'(ref_mem[aa]));
        chk("exclusive", 32'(bus.aux_gnt && bus.cpu_req && !bus.cpu_stall), 32'd0);
        chk("stall_cnt", 32'(stall_cnt), STATS ? 32'(stalls) : 32'd0);
        ob_gnt = bus.aux_gnt; ob_stall = bus.cpu_stall; ob_wr = bus.mem_write;
        ob_addr = bus.mem_addr; ob_ardata = bus.aux_rdata;

        if (srv == 1 && cwe) ref_mem[ca] = cwd;
        if (srv == 2 && awe) ref_mem[aa] = awd;
        if (e_stall && stalls < 65535) stalls++;
        if (!aux_holds) begin
            if (ar && (!cr || aux_blocked >= MAX_WAIT)) begin
                aux_holds = 1'b1; aux_run = 0; aux_blocked = 0;
            end else begin
                aux_blocked = ar ? ((aux_blocked < MAX_WAIT) ? aux_blocked + 1 : MAX_WAIT) : 0;
            end
        end else if (!ar || (cr && aux_run >= BURST_LEN - 1)) begin
            aux_holds = 1'b0; aux_blocked = 0;
        end else begin
            aux_run = (aux_run < BURST_LEN - 1) ? aux_run + 1 : BURST_LEN - 1;
        end
    endtask

    // Asynchronous reset raised mid-cycle with the current inputs still applied.
    task automatic hard_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_aux_gnt",   32'(bus.aux_gnt),   32'd0);
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] smask, gmask;
        int          k, nserved, nbad, dens;
        logic        a_pend, a_we, c_hold, c_req, c_we;
        logic [7:0]  a_addr, a_wd, c_addr, c_wd;

        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of an aux burst, CPU stalled and writing.
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h11);
        step(1, 1, 8'h31, 8'h22, 1, 1, 8'h32, 8'h33);
        chk("s1_in_aux", 32'(ob_gnt), 32'd1);
        hard_reset();
        gmask = '0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
            gmask[i] = ob_gnt;
        end
        chk("s1_post_rst_wait", gmask, 32'h20);

        // Idle CPU: aux write then read back.
        hard_reset();
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5);
        chk("s2_c0_gnt", 32'(ob_gnt), 32'd0);
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5);
        chk("s2_c1_gnt",  32'(ob_gnt),  32'd1);
        chk("s2_c1_wr",   32'(ob_wr),   32'd1);
        chk("s2_c1_addr", 32'(ob_addr), 32'h10);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
        chk("s2_rd_gnt",  32'(ob_gnt),    32'd1);
        chk("s2_rd_data", 32'(ob_ardata), 32'hA5);
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

        // CPU busy every cycle, aux waiting: forced grant and burst limit.
        hard_reset();
        k = 0; smask = '0; gmask = '0; nserved = 0;
        for (int i = 0; i < 14; i++) begin
            step(1, 1, 8'(8'h40 + k), 8'(3 * k + 1), 1, 0, 8'h40, 8'h00);
            smask[i] = ob_stall;
            gmask[i] = ob_gnt;
            if (ob_wr && !ob_gnt) nserved++;
            if (!e_stall) k++;
        end
        chk("s3_stall_mask", smask, 32'h3060);
        chk("s3_gnt_mask",   gmask, 32'h3060);
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("s6_stall_cnt", 32'(stall_cnt), STATS ? 32'd4 : 32'd0);
        chk("s4_cpu_writes", 32'(nserved), 32'd10);
        nbad = 0;
        for (int j = 0; j < 10; j++)
            if (mem[8'h40 + j] !== 8'(3 * j + 1)) nbad++;
        chk("s4_landed", 32'(nbad), 32'd0);

        // Aux holds an idle CPU indefinitely.
        hard_reset();
        gmask = '0;
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 8'h00, 8'h00, 1, 1, 8'(8'h50 + i), 8'(i));
            gmask[i] = ob_gnt;
        end
        chk("s5_gnt_mask", gmask, 32'h7FE);

        // CPU wakes at cycle 6 with the burst count already saturated.
        hard_reset();
        smask = '0; gmask = '0;
        for (int i = 0; i < 8; i++) begin
            step(i >= 6, 0, 8'h50, 8'h00, 1, 0, 8'(8'h60 + i), 8'h00);
            smask[i] = ob_stall;
            gmask[i] = ob_gnt;
        end
        chk("s5_stall_mask", smask, 32'h40);
        chk("s5b_gnt_mask",  gmask, 32'h7E);

        // Randomized traffic: aux holds its request until granted,
        // a stalled CPU holds its access.
        hard_reset();
        a_pend = 0; a_we = 0; a_addr = '0; a_wd = '0;
        c_hold = 0; c_req = 0; c_we = 0; c_addr = '0; c_wd = '0; dens = 2;
        for (int i = 0; i < 2400; i++) begin
            if (i % 200 == 0) dens = int'($urandom_range(0, 4));
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1;
                a_we   = 1'($urandom_range(0, 1));
                a_addr = 8'($urandom_range(0, 15));
                a_wd   = 8'($urandom);
            end
            if (!c_hold) begin
                c_req  = (int'($urandom_range(0, 3)) < dens);
                c_we   = 1'($urandom_range(0, 1));
                c_addr = 8'($urandom_range(0, 15));
                c_wd   = 8'($urandom);
            end
            step(c_req, c_we, c_addr, c_wd, a_pend, a_we, a_addr, a_wd);
            if (e_gnt) a_pend = 0;
            c_hold = e_stall;
        end
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        nbad = 0;
        for (int j = 0; j < 256; j++)
            if (mem[j] !== ref_mem[j]) nbad++;
        chk("rand_mem_image", 32'(nbad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
